seq_mult32: RTL
===============

Name: seq_mult32

Overview:
- Iterative 32x32 unsigned shift-and-add multiplier producing a 64-bit product.
- One 32-bit add per cycle, built on the team's 32-bit ripple-carry adder.
- Sits in the ALU's multicycle path: accepts operands from the operand/issue logic and hands a registered product to writeback.
- Exercises the adder as a sequential datapath stage rather than standalone combinational logic.

Parameters:
- WIDTH, 32, operand width. The block is verified at 32 only; other values are unsupported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  32  multiplicand; captured on an accepted start
- b  in  32  multiplier; captured on an accepted start
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse; product is valid on this cycle
- product  out  64  result register; holds its value until the next completion

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, busy=0, done=0, product=0, internal registers=0. Reset takes priority over all other events, including mid-RUN; the in-flight operation is discarded and done is not pulsed.
- Internal registers: mcand[31:0], acc[31:0] (product high half), mpl[31:0] (multiplier / product low half), cnt[CNT_W-1:0].
- States: IDLE, RUN, DONE.
- IDLE: when start=1, load mcand=a, mpl=b, acc=0, cnt=0, and go to RUN. When start=0, stay in IDLE.
- RUN, each cycle:
  - If mpl[0]=1: {c,sum} = acc + mcand via the 33-bit adder (carry out kept). Otherwise sum=acc, c=0.
  - Update {acc,mpl} <= {c,sum,mpl[31:1]}, i.e. a 65-bit value shifted right by 1.
  - cnt <= cnt+1.
  - When cnt=31 on the current cycle, go to DONE.
- DONE: product <= {acc,mpl} (registered on entry; visible in DONE), done=1 for exactly this one cycle, then unconditionally return to IDLE.
- Latency: start sampled at edge 0, RUN occupies edges 1..32, done is high in the cycle after edge 33. Throughput is one product per 34 cycles.
- start while busy=1 is ignored; no queuing, no error flag.
- a and b may change freely after acceptance; only the captured copies are used.
- Arithmetic: the carry out of each add must be preserved into acc bit 31 after the shift, so no overflow is lost. The full 64-bit product is exact for all inputs.
- product holds its last value through IDLE and the next RUN. It changes only at a DONE or on reset.

Optional Feature:
- Macro: SEQ_MULT_EARLY_TERM_EN.
- Defined: in IDLE, if start=1 and (a==0 or b==0), skip RUN and go directly to DONE with product=0. done is then high in the cycle after edge 1. Nonzero operands are unaffected (full 33-edge latency).
- Undefined: every operation takes full latency; zero operands run all 32 iterations and yield product=0.

Decomposition:
- Shared package (alu_pkg): state enum encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and constants MULT_WIDTH=32, MULT_ITERS=32.
- Sub-module: the existing 32-bit ripple-carry adder, instantiated once with cin=0 and its cout feeding the shift.
- Control FSM and shift registers are kept in seq_mult32 itself.

Test Plan:
- Reset, then a=3, b=5, start pulse → done 1 cycle after the 33rd edge following start; product=64'h0000_0000_0000_000F; busy high from edge 1 until done falls.
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → product=64'hFFFF_FFFE_0000_0001 (carry-preservation check).
- a=32'h8000_0000, b=2, with start held high throughout RUN and a/b changed mid-run → exactly one product=64'h0000_0001_0000_0000. The second start is accepted only after returning to IDLE.
- Start a=7, b=9; assert rst_n=0 at RUN cycle 10 → next cycle busy=0, product=0, no done pulse. A subsequent 6x7 returns 64'd42.
- a=0, b=32'h1234_5678 → product=0; done after 34 cycles without the macro, after 2 cycles with SEQ_MULT_EARLY_TERM_EN.
- Random 200 operand pairs compared against a 64-bit reference model; done must pulse exactly once per accepted start.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU multicycle path.
//   mult_state_e : control state encoding of the iterative multiplier
//   MULT_WIDTH   : operand width of the multiplier datapath
//   MULT_ITERS   : number of shift-and-add iterations per product
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_ITERS = 32;

endpackage : alu_pkg

// File: rtl/seq_mult32_adder.sv
// ---------------------------------------------------------------------------
// seq_mult32_adder
// Ripple-carry adder used as the single add stage of the iterative multiplier.
// Ports:
//   a, b  : WIDTH-bit addends
//   cin   : carry in
//   sum   : WIDTH-bit sum
//   cout  : carry out of the most significant bit
// ---------------------------------------------------------------------------
module seq_mult32_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
        cout = carry[WIDTH];
    end

endmodule : seq_mult32_adder

// File: rtl/seq_mult32.sv
// ---------------------------------------------------------------------------
// seq_mult32
// Iterative unsigned shift-and-add multiplier, one add per cycle, 64-bit
// product. Operands are captured on an accepted start; the product register
// is updated only on completion (or cleared by reset).
//
// Configuration macro:
//   SEQ_MULT_EARLY_TERM_EN : when defined, a start with a zero operand skips
//                            the iteration phase and completes with product 0.
//
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   start   : request, sampled only in IDLE
//   a, b    : multiplicand / multiplier
//   busy    : operation in flight (including the done cycle)
//   done    : one-cycle completion pulse, product valid in this cycle
//   product : result register
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; product holds the last result
// RUN   | one add/shift iteration per cycle, 32 iterations
// DONE  | copy {acc,mpl} into product and pulse done, back to IDLE
// ---------------------------------------------------------------------------
module seq_mult32
    import alu_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    mult_state_e        state_q,   state_d;
    logic [WIDTH-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [WIDTH-1:0]   mpl_q,     mpl_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;

    // Gating the addend with mpl[0] gives sum=acc, carry=0 on a zero bit.
    assign add_b = mpl_q[0] ? mcand_q : '0;

    seq_mult32_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a    (acc_q),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        mpl_d     = mpl_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d = a;
                    mpl_d   = b;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
                    if ((a == '0) || (b == '0)) begin
                        // Clear mpl so DONE copies an all-zero product.
                        mpl_d   = '0;
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                // Carry out lands in acc[MSB] after the shift, so no bit is lost.
                {acc_d, mpl_d} = {add_cout, add_sum, mpl_q[WIDTH-1:1]};
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MULT_ITERS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                product_d = {acc_q, mpl_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy stays up through the done pulse so the product is never
        // presented while the block reports itself idle.
        busy_d = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            acc_q     <= '0;
            mpl_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            mpl_q     <= mpl_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : seq_mult32
